coreapb3_iaddr_sched: RTL and testbench

COREAPB3_IADDR_SCHED -- requirements
Module: coreapb3_iaddr_sched

---
 rtl/coreapb3_iaddr_sched.sv | 193 +++++++++++++++++++
 tb/tb_coreapb3_iaddr_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coreapb3_iaddr_sched.sv
// Two-requester APB3 scheduler with indirect-address window and tag cache.
// Optional tag cache built only when COREAPB3_IADDR_CACHE_EN is defined.
module coreapb3_iaddr_sched #(
   parameter logic [31:0] IADDR_OFFSET = 32'h0000_0000,
   parameter logic [31:0] WIN_BASE     = 32'h0000_1000,
   parameter int          WIN_BITS     = 12
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        REQ0_VALID,
   output logic        REQ0_READY,
   input  logic [31:0] REQ0_ADDR,
   input  logic        REQ0_WRITE,
   input  logic [31:0] REQ0_WDATA,
   output logic        RSP0_VALID,
   input  logic        REQ1_VALID,
   output logic        REQ1_READY,
   input  logic [31:0] REQ1_ADDR,
   input  logic        REQ1_WRITE,
   input  logic [31:0] REQ1_WDATA,
   output logic        RSP1_VALID,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   input  logic        CACHE_INV,
   output logic        PSEL,
   output logic        PENABLE,
   output logic [31:0] PADDR,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   localparam int TW = 32 - WIN_BITS;

   typedef enum logic [2:0] {
      IDLE,
      IA_SETUP,
      IA_ACCESS,
      D_SETUP,
      D_ACCESS,
      RESP
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        gnt_q;
   logic        pri_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        write_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        gnt0;
   logic        gnt1;
   logic        gnt_any;
   logic        hit;
   logic        ia_done;
   logic        d_done;

   // pri_q names the requester that wins when both are pending
   assign gnt1    = REQ1_VALID & (~REQ0_VALID | pri_q);
   assign gnt0    = REQ0_VALID & ~gnt1;
   assign gnt_any = gnt0 | gnt1;
   assign ia_done = (state == IA_ACCESS) & PREADY;
   assign d_done  = (state == D_ACCESS) & PREADY;

`ifdef COREAPB3_IADDR_CACHE_EN
   logic [TW-1:0] req_tag;
   logic [TW-1:0] tag_q;
   logic          vld_q;

   assign req_tag = gnt1 ? REQ1_ADDR[31:WIN_BITS]
                         : REQ0_ADDR[31:WIN_BITS];
   assign hit     = vld_q & ~CACHE_INV & (tag_q == req_tag);

   // invalidate has priority over a tag load in the same cycle
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         tag_q <= '0;
         vld_q <= 1'b0;
      end else begin
         if (ia_done && !PSLVERR)
            tag_q <= addr_q[31:WIN_BITS];
         if (CACHE_INV)
            vld_q <= 1'b0;
         else if (ia_done)
            vld_q <= ~PSLVERR;
      end
   end
`else
   logic unused_cache;

   assign unused_cache = CACHE_INV;
   assign hit          = 1'b0;
`endif

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state   <= IDLE;
         gnt_q   <= 1'b0;
         pri_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && gnt_any) begin
            gnt_q   <= gnt1;
            pri_q   <= ~gnt1;
            addr_q  <= gnt1 ? REQ1_ADDR : REQ0_ADDR;
            wdata_q <= gnt1 ? REQ1_WDATA : REQ0_WDATA;
            write_q <= gnt1 ? REQ1_WRITE : REQ0_WRITE;
         end
         if (ia_done && PSLVERR) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
         if (d_done) begin
            rdata_q <= write_q ? 32'h0 : PRDATA;
            err_q   <= PSLVERR;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:
            if (gnt_any)
               state_nx = hit ? D_SETUP : IA_SETUP;
         IA_SETUP:
            state_nx = IA_ACCESS;
         IA_ACCESS:
            if (PREADY)
               state_nx = PSLVERR ? RESP : D_SETUP;
         D_SETUP:
            state_nx = D_ACCESS;
         D_ACCESS:
            if (PREADY)
               state_nx = RESP;
         RESP:
            state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   always_comb begin
      PSEL       = 1'b0;
      PENABLE    = 1'b0;
      PADDR      = '0;
      PWRITE     = 1'b0;
      PWDATA     = '0;
      REQ0_READY = 1'b0;
      REQ1_READY = 1'b0;
      RSP0_VALID = 1'b0;
      RSP1_VALID = 1'b0;
      case (state)
         IDLE: begin
            REQ0_READY = gnt0;
            REQ1_READY = gnt1;
         end
         IA_SETUP, IA_ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = (state == IA_ACCESS);
            PADDR   = IADDR_OFFSET;
            PWRITE  = 1'b1;
            PWDATA  = {addr_q[31:WIN_BITS], {WIN_BITS{1'b0}}};
         end
         D_SETUP, D_ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = (state == D_ACCESS);
            PADDR   = WIN_BASE |
                      {{TW{1'b0}}, addr_q[WIN_BITS-1:0]};
            PWRITE  = write_q;
            PWDATA  = write_q ? wdata_q : 32'h0;
         end
         RESP: begin
            RSP0_VALID = ~gnt_q;
            RSP1_VALID = gnt_q;
         end
         default: ;
      endcase
   end

   assign RSP_RDATA = rdata_q;
   assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_coreapb3_iaddr_sched.sv
// Bench for coreapb3_iaddr_sched: directed scenarios then random traffic.
// Honours COREAPB3_IADDR_CACHE_EN to select the expected cache behaviour.
module tb_coreapb3_iaddr_sched;

   localparam logic [31:0] IA_OFF = 32'h0000_0000;
   localparam logic [31:0] WBASE  = 32'h0000_1000;
   localparam int          WB     = 12;
   localparam logic [31:0] LOMASK = (32'h1 << WB) - 1;
`ifdef COREAPB3_IADDR_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   localparam int M_IDLE = 0, M_SETUP = 1, M_ACCESS = 2, M_RESP = 3;

   logic        PCLK, PRESET;
   logic        REQ0_VALID, REQ0_READY, REQ0_WRITE, RSP0_VALID;
   logic [31:0] REQ0_ADDR, REQ0_WDATA;
   logic        REQ1_VALID, REQ1_READY, REQ1_WRITE, RSP1_VALID;
   logic [31:0] REQ1_ADDR, REQ1_WDATA;
   logic [31:0] RSP_RDATA;
   logic        RSP_ERR, CACHE_INV;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;

   coreapb3_iaddr_sched dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
      .REQ0_ADDR(REQ0_ADDR), .REQ0_WRITE(REQ0_WRITE),
      .REQ0_WDATA(REQ0_WDATA), .RSP0_VALID(RSP0_VALID),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
      .REQ1_ADDR(REQ1_ADDR), .REQ1_WRITE(REQ1_WRITE),
      .REQ1_WDATA(REQ1_WDATA), .RSP1_VALID(RSP1_VALID),
      .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .CACHE_INV(CACHE_INV),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wd;
      bit          ia;
      logic [31:0] tag;
   } xfer_t;

   int total = 0, bad = 0;
   xfer_t eq[$];
   bit          pend[2];
   logic [31:0] p_addr[2], p_wd[2];
   bit          p_wr[2];

   // stimulus knobs
   bit          d_rst, rnd_mode, ia_err, rst_on_dacc;
   int          hold_n;
   logic [31:0] d_rdata;

   // reference model
   int          mode;
   bit          m_pri, m_cv, rst_seen;
   logic [31:0] m_tag, e_rd;
   bit          e_err;
   int          m_cur;

   // observations
   int          cyc_no, g_obs, last_lat, rsp_cnt, ia_obs, d_obs;
   logic [31:0] last_rd_obs;
   bit          last_err_obs;
   int          glog[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic post(input int n, input logic [31:0] a,
                       input bit w, input logic [31:0] d);
      pend[n]   = 1'b1;
      p_addr[n] = a;
      p_wr[n]   = w;
      p_wd[n]   = d;
   endtask

   task automatic model_reset();
      mode  = M_IDLE;
      m_pri = 1'b0;
      m_cv  = 1'b0;
      m_tag = '0;
      e_rd  = '0;
      e_err = 1'b0;
      eq.delete();
   endtask

   task automatic observe();
      int n;
      logic [31:0] a, tg;
      bit hit;
      xfer_t t;
      if (PRESET) begin
         model_reset();
         rst_seen = 1'b1;
         return;
      end
      if (rst_seen) begin
         check("rst_psel", PSEL, 0);
         check("rst_penable", PENABLE, 0);
         check("rst_paddr", PADDR, 0);
         check("rst_pwrite", PWRITE, 0);
         check("rst_pwdata", PWDATA, 0);
         check("rst_hs", {REQ1_READY, REQ0_READY,
                          RSP1_VALID, RSP0_VALID}, 0);
         check("rst_rdata", RSP_RDATA, 0);
         check("rst_err", RSP_ERR, 0);
         rst_seen = 1'b0;
      end
      if (REQ0_READY || REQ1_READY) begin
         glog.push_back(int'(REQ1_READY));
         g_obs = cyc_no;
      end
      if (RSP0_VALID || RSP1_VALID) begin
         rsp_cnt++;
         last_lat     = cyc_no - g_obs;
         last_rd_obs  = RSP_RDATA;
         last_err_obs = RSP_ERR;
      end
      if (PSEL && PENABLE && PREADY) begin
         if (PADDR == IA_OFF) ia_obs++;
         else d_obs++;
      end
      if (mode != M_RESP) begin
         check("rdata_hold", RSP_RDATA, e_rd);
         check("err_hold", RSP_ERR, e_err);
      end
      case (mode)
         M_IDLE: begin
            n = -1;
            if (REQ0_VALID && REQ1_VALID) n = int'(m_pri);
            else if (REQ0_VALID) n = 0;
            else if (REQ1_VALID) n = 1;
            check("ready0", REQ0_READY, n == 0);
            check("ready1", REQ1_READY, n == 1);
            check("idle_apb", {PSEL, PENABLE, PWRITE}, 0);
            check("idle_paddr", PADDR, 0);
            check("idle_pwdata", PWDATA, 0);
            check("idle_rsp", {RSP1_VALID, RSP0_VALID}, 0);
            if (n >= 0) begin
               a   = p_addr[n];
               tg  = a >> WB;
               hit = CACHE && m_cv && !CACHE_INV && (m_tag == tg);
               if (!hit)
                  eq.push_back('{IA_OFF, 1'b1, tg << WB, 1'b1, tg});
               eq.push_back('{WBASE | (a & LOMASK), p_wr[n],
                              p_wr[n] ? p_wd[n] : 32'h0, 1'b0, tg});
               m_pri   = (n == 0);
               m_cur   = n;
               pend[n] = 1'b0;
               mode    = M_SETUP;
            end
         end
         M_SETUP, M_ACCESS: begin
            t = eq[0];
            check("psel", PSEL, 1);
            check("penable", PENABLE, mode == M_ACCESS);
            check("paddr", PADDR, t.addr);
            check("pwrite", PWRITE, t.wr);
            check("pwdata", PWDATA, t.wd);
            check("busy_hs", {REQ1_READY, REQ0_READY,
                              RSP1_VALID, RSP0_VALID}, 0);
            if (mode == M_SETUP) begin
               mode = M_ACCESS;
            end else if (PREADY) begin
               void'(eq.pop_front());
               if (t.ia && PSLVERR) begin
                  m_cv  = 1'b0;
                  e_rd  = '0;
                  e_err = 1'b1;
                  eq.delete();
                  mode  = M_RESP;
               end else if (t.ia) begin
                  m_tag = t.tag;
                  m_cv  = 1'b1;
                  mode  = M_SETUP;
               end else begin
                  e_rd  = t.wr ? 32'h0 : PRDATA;
                  e_err = PSLVERR;
                  mode  = M_RESP;
               end
            end
         end
         default: begin
            check("rsp0", RSP0_VALID, m_cur == 0);
            check("rsp1", RSP1_VALID, m_cur == 1);
            check("rsp_rdata", RSP_RDATA, e_rd);
            check("rsp_err", RSP_ERR, e_err);
            check("resp_apb", {PSEL, PENABLE, PWRITE}, 0);
            check("resp_paddr", PADDR, 0);
            check("resp_ready", {REQ1_READY, REQ0_READY}, 0);
            mode = M_IDLE;
         end
      endcase
      if (CACHE_INV) m_cv = 1'b0;
   endtask

   task automatic cyc();
      bit pr, rdy, dacc;
      @(posedge PCLK);
      #1;
      cyc_no++;
      pr   = d_rst;
      rdy  = rnd_mode ? ($urandom % 3 != 0) : 1'b1;
      dacc = PSEL && PENABLE && (PADDR != IA_OFF);
      if (hold_n > 0 && dacc) begin
         rdy = 1'b0;
         hold_n--;
      end
      if (rst_on_dacc && dacc) begin
         pr          = 1'b1;
         rdy         = 1'b0;
         rst_on_dacc = 1'b0;
      end
      PRESET    = pr;
      PREADY    = rdy;
      PSLVERR   = rnd_mode ? ($urandom % 10 == 0)
                           : (ia_err && PSEL && PADDR == IA_OFF);
      PRDATA    = rnd_mode ? $urandom : d_rdata;
      CACHE_INV = rnd_mode ? ($urandom % 16 == 0) : 1'b0;
      REQ0_VALID = pend[0] && !pr && !rst_seen;
      REQ0_ADDR  = p_addr[0];
      REQ0_WRITE = p_wr[0];
      REQ0_WDATA = p_wd[0];
      REQ1_VALID = pend[1] && !pr && !rst_seen;
      REQ1_ADDR  = p_addr[1];
      REQ1_WRITE = p_wr[1];
      REQ1_WDATA = p_wd[1];
      @(negedge PCLK);
      observe();
   endtask

   task automatic do_reset();
      d_rst = 1'b1;
      cyc();
      d_rst = 1'b0;
      cyc();
   endtask

   task automatic wait_rsp(input int maxc);
      int c0, i;
      c0 = rsp_cnt;
      i  = 0;
      while (rsp_cnt == c0 && i < maxc) begin
         cyc();
         i++;
      end
      check("rsp_seen", rsp_cnt != c0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ia0, d0, c0, sel;
      logic [31:0] bases[3];
      bases[0] = 32'h3000_0000;
      bases[1] = 32'h3000_1000;
      bases[2] = 32'h7FFF_F000;
      PRESET = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      CACHE_INV = 1'b0;
      REQ0_VALID = 1'b0; REQ0_ADDR = '0; REQ0_WRITE = 1'b0;
      REQ0_WDATA = '0;
      REQ1_VALID = 1'b0; REQ1_ADDR = '0; REQ1_WRITE = 1'b0;
      REQ1_WDATA = '0;
      model_reset();
      d_rdata = 32'h1234_5678;
      do_reset();

      ia0 = ia_obs;
      post(0, 32'h3000_0004, 1'b0, 32'h0);
      wait_rsp(30);
      check("t1_lat", last_lat, 5);
      check("t1_ia", ia_obs - ia0, 1);
      check("t1_rdata", last_rd_obs, 32'h1234_5678);

      ia0 = ia_obs;
      post(0, 32'h3000_0008, 1'b0, 32'h0);
      wait_rsp(30);
      check("t2_lat", last_lat, CACHE ? 3 : 5);
      check("t2_ia", ia_obs - ia0, CACHE ? 0 : 1);

      do_reset();
      glog.delete();
      post(0, 32'h3000_0010, 1'b0, 32'h0);
      post(1, 32'h3000_0014, 1'b1, 32'h0000_0011);
      wait_rsp(30);
      wait_rsp(30);
      post(0, 32'h3000_0018, 1'b1, 32'h0000_0022);
      post(1, 32'h3000_001C, 1'b0, 32'h0);
      wait_rsp(30);
      wait_rsp(30);
      check("t3_ngrant", glog.size(), 4);
      if (glog.size() == 4) begin
         check("t3_g0", glog[0], 0);
         check("t3_g1", glog[1], 1);
         check("t3_g2", glog[2], 0);
         check("t3_g3", glog[3], 1);
      end

      hold_n  = 3;
      d_rdata = 32'hA5A5_0001;
      post(0, 32'h3000_0040, 1'b0, 32'h0);
      wait_rsp(40);
      check("t4_rdata", last_rd_obs, 32'hA5A5_0001);
      check("t4_lat", last_lat, CACHE ? 6 : 8);

      ia_err = 1'b1;
      ia0 = ia_obs;
      d0  = d_obs;
      post(1, 32'h5000_0020, 1'b1, 32'hDEAD_BEEF);
      wait_rsp(30);
      check("t5_err", last_err_obs, 1);
      check("t5_nodata", d_obs - d0, 0);
      check("t5_ia", ia_obs - ia0, 1);
      ia_err = 1'b0;
      ia0 = ia_obs;
      post(1, 32'h5000_0028, 1'b0, 32'h0);
      wait_rsp(30);
      check("t5b_ia", ia_obs - ia0, 1);
      check("t5b_err", last_err_obs, 0);

      c0 = rsp_cnt;
      rst_on_dacc = 1'b1;
      post(0, 32'h5000_0030, 1'b0, 32'h0);
      for (int i = 0; i < 20 && rst_on_dacc; i++) cyc();
      check("t6_rst_hit", rst_on_dacc, 0);
      cyc();
      check("t6_psel", PSEL, 0);
      repeat (4) cyc();
      check("t6_norsp", rsp_cnt - c0, 0);
      ia0 = ia_obs;
      post(0, 32'h5000_0030, 1'b0, 32'h0);
      wait_rsp(30);
      check("t6_ia", ia_obs - ia0, 1);

      rnd_mode = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (!pend[n] && $urandom % 3 == 0) begin
               sel = $urandom % 3;
               post(n, bases[sel] | ($urandom & 32'hFFC),
                    1'($urandom % 2), $urandom);
            end
         end
         d_rst = ($urandom % 400 == 0);
         cyc();
         d_rst = 1'b0;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
